// File: rtl/alu_mem_pkg.sv
// Shared definitions for the execute/memory slice of the 16-bit CPU.
// Holds the ALUOp, Funct and immediate opcode encodings, the 3-bit ALU
// Operation encodings, the full 4-bit ALUCtrl words {BNegate, Operation},
// and the control-decode function that maps ALUOp/Funct/Opcode to ALUCtrl.
package alu_mem_pkg;

  // ALUOp: selects how the control word is derived.
  localparam logic [1:0] ALUOP_MEM = 2'b00;  // load/store address add
  localparam logic [1:0] ALUOP_BR  = 2'b01;  // branch compare subtract
  localparam logic [1:0] ALUOP_R   = 2'b10;  // R-type, decode Funct
  localparam logic [1:0] ALUOP_I   = 2'b11;  // immediate, decode Opcode

  // R-type Funct field (instruction[3:0]).
  localparam logic [3:0] FUNCT_AND = 4'b0000;
  localparam logic [3:0] FUNCT_OR  = 4'b0001;
  localparam logic [3:0] FUNCT_ADD = 4'b0010;
  localparam logic [3:0] FUNCT_SUB = 4'b0011;
  localparam logic [3:0] FUNCT_SLT = 4'b0100;
  localparam logic [3:0] FUNCT_XOR = 4'b0101;
  localparam logic [3:0] FUNCT_NOR = 4'b0110;
  localparam logic [3:0] FUNCT_SLL = 4'b0111;
  localparam logic [3:0] FUNCT_SRL = 4'b1000;

  // Immediate opcodes (instruction[15:13]).
  localparam logic [2:0] OPC_ADDI = 3'b001;
  localparam logic [2:0] OPC_ANDI = 3'b010;
  localparam logic [2:0] OPC_ORI  = 3'b011;
  localparam logic [2:0] OPC_SLTI = 3'b100;

  // ALU Operation field (ALUCtrl[2:0]).
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SLT = 3'b011,
    OP_XOR = 3'b100,
    OP_NOR = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } alu_op_e;

  // Full control words {BNegate, Operation}.
  localparam logic [3:0] CTRL_AND = 4'h0;
  localparam logic [3:0] CTRL_OR  = 4'h1;
  localparam logic [3:0] CTRL_ADD = 4'h2;
  localparam logic [3:0] CTRL_XOR = 4'h4;
  localparam logic [3:0] CTRL_NOR = 4'h5;
  localparam logic [3:0] CTRL_SLL = 4'h6;
  localparam logic [3:0] CTRL_SRL = 4'h7;
  localparam logic [3:0] CTRL_SUB = 4'hA;
  localparam logic [3:0] CTRL_SLT = 4'hB;

  // Control decode. Unlisted Funct/Opcode values fall back to ADD so an
  // unknown instruction still produces a well-defined address/result.
  function automatic logic [3:0] decode_ctrl(input logic [1:0] alu_op,
                                             input logic [3:0] funct,
                                             input logic [2:0] opcode);
    logic [3:0] ctrl;
    ctrl = CTRL_ADD;
    case (alu_op)
      ALUOP_MEM: ctrl = CTRL_ADD;
      ALUOP_BR:  ctrl = CTRL_SUB;
      ALUOP_R: begin
        case (funct)
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_SLT: ctrl = CTRL_SLT;
          FUNCT_XOR: ctrl = CTRL_XOR;
          FUNCT_NOR: ctrl = CTRL_NOR;
          FUNCT_SLL: ctrl = CTRL_SLL;
          FUNCT_SRL: ctrl = CTRL_SRL;
          default:   ctrl = CTRL_ADD;
        endcase
      end
      default: begin  // ALUOP_I
        case (opcode)
          OPC_ADDI: ctrl = CTRL_ADD;
          OPC_ANDI: ctrl = CTRL_AND;
          OPC_ORI:  ctrl = CTRL_OR;
          OPC_SLTI: ctrl = CTRL_SLT;
          default:  ctrl = CTRL_ADD;
        endcase
      end
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_mem_dmem.sv
// Byte-addressed, word-wide data memory (little-endian).
// Ports:
//   clk        rising-edge write clock
//   rst        asynchronous active-high clear of every byte
//   addr       byte address, already reduced to log2(MEM_BYTES) bits
//   write_data 16-bit store data
//   mem_write  store enable
//   mem_read   load enable
//   read_data  combinational load data, 0 when not reading or in reset
module alu_mem_dmem #(
  parameter int MEM_BYTES = 256,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   write_data,
  input  logic          mem_write,
  input  logic          mem_read,
  output logic [15:0]   read_data
);

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] addr_lo;
  logic [AW-1:0] addr_hi;

  // Odd addresses align down to the word; the high byte is the odd partner.
  // NOTE: every variable written in always_comb is assigned before any
  // conditional update, so no path can leave it holding a stale value.
  always_comb begin
    addr_lo    = addr;
    addr_lo[0] = 1'b0;
    addr_hi    = addr;
    addr_hi[0] = 1'b1;
  end

  // NOTE: this memory is cleared by the async reset because a reset is
  // architecturally required to discard stores; that forces flops rather
  // than a RAM macro, which is acceptable at this size.
  // NOTE: sequential state is assigned with <= so all bytes update together
  // at the edge and reads in the same timestep still see the old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[addr_lo] <= write_data[7:0];
      mem[addr_hi] <= write_data[15:8];
    end
  end

  assign read_data = (mem_read && !rst) ? {mem[addr_hi], mem[addr_lo]} : 16'h0000;

endmodule

// File: rtl/alu_mem_unit.sv
// Execute/memory slice of the 16-bit single-cycle CPU: ALU control decode,
// 16-bit ALU with Zero/Overflow/CarryOut, and the data memory addressed by
// the ALU result. Everything is combinational except memory writes.
// Ports:
//   Clock, Reset         rising-edge clock; async active-high reset (memory)
//   ALUOp, Funct, Opcode control-decode inputs
//   A, B                 ALU operands
//   WriteData            store data
//   MemWrite, MemRead    memory enables
//   ALUCtrl              decoded {BNegate, Operation}
//   Result               ALU result, also the memory byte address
//   Zero, Overflow, CarryOut  ALU flags
//   ReadData             load data
module alu_mem_unit
  import alu_mem_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  ALUOp,
  input  logic [3:0]  Funct,
  input  logic [2:0]  Opcode,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [3:0]  ALUCtrl,
  output logic [15:0] Result,
  output logic        Zero,
  output logic        Overflow,
  output logic        CarryOut,
  output logic [15:0] ReadData
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [3:0]  ctrl;
  logic        bnegate;
  alu_op_e     op;
  logic [15:0] bi;
  logic [16:0] sum;
  logic        sum_ovf;
  logic [15:0] alu_result;

  assign ctrl    = decode_ctrl(ALUOp, Funct, Opcode);
  assign bnegate = ctrl[3];
  assign op      = alu_op_e'(ctrl[2:0]);

  // Subtraction is A + ~B + 1; the carry-in is BNegate itself.
  assign bi  = bnegate ? ~B : B;
  assign sum = {1'b0, A} + {1'b0, bi} + {16'b0, bnegate};

  // Signed overflow: operands of equal sign producing a sum of the other sign.
  assign sum_ovf = (A[15] == bi[15]) && (sum[15] != A[15]);

  always_comb begin
    alu_result = '0;
    case (op)
      OP_AND: alu_result = A & bi;
      OP_OR:  alu_result = A | bi;
      OP_ADD: alu_result = sum[15:0];
      // The true signed comparison is the sign of A-B corrected for overflow.
      OP_SLT: alu_result = {15'b0, sum[15] ^ sum_ovf};
      OP_XOR: alu_result = A ^ B;
      OP_NOR: alu_result = ~(A | B);
      OP_SLL: alu_result = A << B[3:0];
      OP_SRL: alu_result = A >> B[3:0];
      default: alu_result = '0;
    endcase
  end

  assign ALUCtrl  = ctrl;
  assign Result   = alu_result;
  assign Zero     = (alu_result == 16'h0000);
  assign Overflow = (op == OP_ADD) && sum_ovf;
  assign CarryOut = ((op == OP_ADD) || (op == OP_SLT)) && sum[16];

  alu_mem_dmem #(
    .MEM_BYTES(MEM_BYTES)
  ) u_dmem (
    .clk       (Clock),
    .rst       (Reset),
    .addr      (alu_result[AW-1:0]),
    .write_data(WriteData),
    .mem_write (MemWrite),
    .mem_read  (MemRead),
    .read_data (ReadData)
  );

endmodule

// File: tb/tb_alu_mem_unit.sv
// Self-checking bench for alu_mem_unit: directed and random transactions,
// each pushing its expected response into a queue that a separate monitor
// pops and compares mid-cycle.
module tb_alu_mem_unit;

  localparam int MEM_BYTES = 256;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  ALUOp = '0;
  logic [3:0]  Funct = '0;
  logic [2:0]  Opcode = '0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [3:0]  ALUCtrl;
  logic [15:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;
  logic [15:0] ReadData;

  alu_mem_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ALUOp    (ALUOp),
    .Funct    (Funct),
    .Opcode   (Opcode),
    .A        (A),
    .B        (B),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ALUCtrl  (ALUCtrl),
    .Result   (Result),
    .Zero     (Zero),
    .Overflow (Overflow),
    .CarryOut (CarryOut),
    .ReadData (ReadData)
  );

  always #5 Clock = ~Clock;

  typedef enum {M_AND, M_OR, M_ADD, M_SUB, M_SLT, M_XOR, M_NOR, M_SLL, M_SRL} mn_e;

  typedef struct {
    int          id;
    logic [3:0]  ctrl;
    logic [15:0] res;
    logic        z;
    logic        v;
    logic        c;
    logic [15:0] rd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [MEM_BYTES];
  int         checks = 0;
  int         failures = 0;
  int         txn_id = 0;

  task automatic check(input string name, input int id,
                       input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s txn=%0d got=%h expected=%h", name, id, actual, expected);
    end
  endtask

  // Reference: mnemonic chosen from the instruction tables, then plain
  // integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [1:0] aluop, input logic [3:0] funct,
                                 input logic [2:0] opcode,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    mn_e  mn;
    int   ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    mn = M_ADD;
    if (aluop == 2'd1) mn = M_SUB;
    else if (aluop == 2'd2) begin
      case (funct)
        4'd0: mn = M_AND;  4'd1: mn = M_OR;   4'd2: mn = M_ADD;
        4'd3: mn = M_SUB;  4'd4: mn = M_SLT;  4'd5: mn = M_XOR;
        4'd6: mn = M_NOR;  4'd7: mn = M_SLL;  4'd8: mn = M_SRL;
        default: mn = M_ADD;
      endcase
    end else if (aluop == 2'd3) begin
      case (opcode)
        3'd1: mn = M_ADD;  3'd2: mn = M_AND;
        3'd3: mn = M_OR;   3'd4: mn = M_SLT;
        default: mn = M_ADD;
      endcase
    end
    e.id = 0; e.v = 1'b0; e.c = 1'b0; e.rd = '0; r = 0; e.ctrl = 4'h2;
    case (mn)
      M_AND: begin e.ctrl = 4'h0; r = ua & ub; end
      M_OR:  begin e.ctrl = 4'h1; r = ua | ub; end
      M_ADD: begin
        e.ctrl = 4'h2; r = ua + ub; e.c = (r > 65535);
        sr = sa + sb; e.v = (sr > 32767) || (sr < -32768);
      end
      M_SUB: begin
        e.ctrl = 4'hA; r = ua - ub; e.c = (ua >= ub);
        sr = sa - sb; e.v = (sr > 32767) || (sr < -32768);
      end
      M_SLT: begin e.ctrl = 4'hB; r = (sa < sb) ? 1 : 0; e.c = (ua >= ub); end
      M_XOR: begin e.ctrl = 4'h4; r = ua ^ ub; end
      M_NOR: begin e.ctrl = 4'h5; r = ~(ua | ub); end
      M_SLL: begin e.ctrl = 4'h6; r = ua * (1 << (ub % 16)); end
      M_SRL: begin e.ctrl = 4'h7; r = ua / (1 << (ub % 16)); end
      default: r = 0;
    endcase
    e.res = 16'(r);
    e.z   = (e.res == 16'h0000);
    return e;
  endfunction

  // Drives one transaction just after a rising edge; its expectation reflects
  // memory contents before the next edge, which is when a store lands.
  task automatic txn(input logic [1:0] aluop, input logic [3:0] funct,
                     input logic [2:0] opcode, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] wd,
                     input logic mw, input logic mr, input logic rst);
    exp_t e;
    int   ea;
    @(posedge Clock);
    #1;
    ALUOp = aluop; Funct = funct; Opcode = opcode; A = a; B = b;
    WriteData = wd; MemWrite = mw; MemRead = mr; Reset = rst;
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
    end
    e    = model(aluop, funct, opcode, a, b);
    e.id = txn_id;
    txn_id++;
    ea   = (int'(e.res) % MEM_BYTES) & ~1;
    e.rd = (mr && !rst) ? {model_mem[ea + 1], model_mem[ea]} : 16'h0000;
    exp_q.push_back(e);
    if (mw && !rst) begin
      model_mem[ea]     = wd[7:0];
      model_mem[ea + 1] = wd[15:8];
    end
  endtask

  // Monitor: compares every pending expectation against the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("alu_ctrl",  e.id, {12'b0, ALUCtrl}, {12'b0, e.ctrl});
        check("result",    e.id, Result, e.res);
        check("zero",      e.id, {15'b0, Zero}, {15'b0, e.z});
        check("overflow",  e.id, {15'b0, Overflow}, {15'b0, e.v});
        check("carry_out", e.id, {15'b0, CarryOut}, {15'b0, e.c});
        check("read_data", e.id, ReadData, e.rd);
      end
    end
  end

  initial begin
    logic [15:0] edge_vals [5];
    logic [1:0]  aluop;
    logic [15:0] a, b;
    logic        mw;
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'h0001; edge_vals[2] = 16'h7FFF;
    edge_vals[3] = 16'h8000; edge_vals[4] = 16'hFFFF;
    for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
    #2 Reset = 1'b1;

    // Under reset: ALU still combinational, ReadData forced to 0.
    txn(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'h1234, 1'b0, 1'b1, 1'b1);
    // Directed ALU cases.
    txn(2'b10, 4'h3, 3'h0, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);
    txn(2'b00, 4'h0, 3'h0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    txn(2'b00, 4'h0, 3'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    txn(2'b10, 4'h4, 3'h0, 16'hFFFE, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0);
    txn(2'b10, 4'h4, 3'h0, 16'h0003, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0);
    txn(2'b10, 4'h7, 3'h0, 16'h0001, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0);
    txn(2'b10, 4'h8, 3'h0, 16'h8000, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0);
    txn(2'b10, 4'hF, 3'h0, 16'h1234, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b0);
    txn(2'b11, 4'h0, 3'h4, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    txn(2'b01, 4'h0, 3'h0, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    // Store then loads: aligned, odd, wrapped, and disabled read.
    txn(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    txn(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'h0000, 1'b0, 1'b1, 1'b0);
    txn(2'b00, 4'h0, 3'h0, 16'h0011, 16'h0004, 16'h0000, 1'b0, 1'b1, 1'b0);
    txn(2'b00, 4'h0, 3'h0, 16'h0110, 16'h0004, 16'h0000, 1'b0, 1'b1, 1'b0);
    txn(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0);
    // Read and write together: old word this cycle, new word next cycle.
    txn(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'hCAFE, 1'b1, 1'b1, 1'b0);
    txn(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'h0000, 1'b0, 1'b1, 1'b0);
    // Async reset mid-cycle, dropped store under reset, read after release.
    txn(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'h0000, 1'b0, 1'b1, 1'b1);
    txn(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'h5A5A, 1'b1, 1'b0, 1'b1);
    txn(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Random phase.
    for (int n = 0; n < 300; n++) begin
      aluop = 2'($urandom_range(0, 3));
      if (aluop == 2'b00) begin
        a  = 16'($urandom_range(0, 600));
        b  = 16'($urandom_range(0, 15));
        mw = 1'($urandom_range(0, 1));
      end else begin
        a  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
        mw = 1'b0;
      end
      txn(aluop, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), a, b,
          16'($urandom), mw, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    // Let the monitor drain; a stuck queue counts as a failure.
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge Clock);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
